vga_sync: RTL

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/mod_counter.sv | 44 ++++
 rtl/vga_sync.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the vga_sync slice.
// Holds the default 640x480@60 timing numbers, the derived line/frame totals,
// the counter width limit, and a helper that maps "in sync pulse" onto the
// configured sync polarity.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  // Sync line level for a pixel: asserted level inside the pulse, idle outside.
  function automatic logic sync_level(input logic in_pulse, input logic pol);
    return in_pulse ? pol : ~pol;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable.
// Ports:
//   i_clk   - clock, all state on rising edge
//   i_rst   - synchronous active-high reset, loads MODULUS-1 so the first
//             enabled edge after reset lands on 0
//   i_ce    - advance enable
//   o_count - registered count, 0..MODULUS-1
//   o_next  - value o_count takes on the next edge (combinational), used by
//             the parent to register decodes aligned with the count
//   o_wrap  - high when the next edge wraps the count to 0 (includes i_ce)
module mod_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic w_at_last;

  always_comb begin
    w_at_last = (o_count == LAST);
    o_wrap    = i_ce && w_at_last;
    o_next    = o_count;
    if (i_ce) begin
      o_next = w_at_last ? '0 : o_count + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= LAST;
    end else begin
      o_count <= o_next;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator.
// Produces pixel/line counters and registered hsync/vsync/video_on and
// line/frame start strobes. All decoded outputs are computed from the next
// counter values so they describe the same pixel as x/y in the same cycle.
// Ports:
//   clk         - pixel clock
//   rst         - synchronous active-high reset (wins over ce)
//   ce          - pixel advance enable; outputs hold while low
//   hsync/vsync - sync pulses, asserted level = SYNC_POL
//   video_on    - current pixel is inside the visible area
//   x, y        - current pixel column / line
//   line_start  - x == 0
//   frame_start - x == 0 and y == 0
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_timing
    $error("vga_sync: timing totals exceed the 10-bit counter range");
  end

  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_h_wrap;
  logic       w_v_wrap;

  mod_counter #(
    .MODULUS (H_TOT),
    .WIDTH   (CNT_W)
  ) u_hcnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ce    (ce),
    .o_count (x),
    .o_next  (w_x_next),
    .o_wrap  (w_h_wrap)
  );

  // Vertical counter only advances on the horizontal wrap; w_h_wrap already
  // carries ce, so a frozen pixel clock also freezes the line count.
  mod_counter #(
    .MODULUS (V_TOT),
    .WIDTH   (CNT_W)
  ) u_vcnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_ce    (w_h_wrap),
    .o_count (y),
    .o_next  (w_y_next),
    .o_wrap  (w_v_wrap)
  );

  logic w_unused;
  assign w_unused = w_v_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= sync_level((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST), SYNC_POL);
      vsync       <= sync_level((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST), SYNC_POL);
      video_on    <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
      line_start  <= (w_x_next == '0);
      frame_start <= (w_x_next == '0) && (w_y_next == '0);
    end
  end

endmodule
